// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared types and constants for the CPU trace probe
// Contents: capture state enum, read page constants, status channel indices.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LIVE   = 8'h00;
  localparam logic [7:0] STATUS = 8'hFF;

  localparam logic [7:0] ST_STATE    = 8'd0;
  localparam logic [7:0] ST_COUNT    = 8'd1;
  localparam logic [7:0] ST_PRE_TRIG = 8'd2;
  localparam logic [7:0] ST_TRIG_HIT = 8'd3;

endpackage

// File: rtl/cpu_trace_probe_if.sv
// rtl/cpu_trace_probe_if.sv - probe bus and check read port bundle
// Signals: probe_bus/probe_valid (CPU datapath side), check_addr/check_data (debug unit side).
// master: drives probe bus and read address; slave: the probe, returns check_data.
interface cpu_trace_probe_if #(
  parameter int NUM_CH = 20,
  parameter int DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] probe_bus;
  logic                     probe_valid;
  logic [31:0]              check_addr;
  logic [31:0]              check_data;

  modport master (output probe_bus, output probe_valid, output check_addr, input check_data);
  modport slave  (input probe_bus, input probe_valid, input check_addr, output check_data);
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace history storage
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Contents are deliberately not reset; validity is tracked by the owner.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_probe.sv
// rtl/cpu_trace_probe.sv - live probe readout with triggered trace buffer
// Ports: clk, rstn (async active-low); bus (probe_bus/probe_valid in, check_addr in,
// check_data out); arm pulse; trig_ch/trig_val trigger setup; trig_hit status out.
module cpu_trace_probe
  import cpu_trace_pkg::*;
#(
  parameter int NUM_CH    = 20,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  cpu_trace_probe_if.slave     bus,
  input  logic                 arm,
  input  logic [7:0]           trig_ch,
  input  logic [31:0]          trig_val,
  output logic                 trig_hit
);

  localparam int BUS_W = NUM_CH * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_TRIG - 1);

  // Zero-extended channel k (1-based); out-of-range channels read 0.
  function automatic logic [31:0] pick(input logic [BUS_W-1:0] b, input logic [7:0] ch);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 8'(k + 1)) v = 32'(b[k*DATA_W +: DATA_W]);
    end
    return v;
  endfunction

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] post_cnt;
  logic [PTR_W-1:0] pre_trig;

  logic             wr_en;
  logic             trig_fire;
  logic [PTR_W-1:0] rd_idx;
  logic [BUS_W-1:0] ram_rdata;
  logic [BUS_W-1:0] entry;
  logic [31:0]      rd_data;
  logic [7:0]       page;
  logic [7:0]       ch;
  logic [7:0]       e;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^bus.check_addr[31:16];

  assign page = bus.check_addr[15:8];
  assign ch   = bus.check_addr[7:0];
  assign e    = page - 8'd1;

  // arm has priority over a coincident sample.
  assign wr_en = bus.probe_valid && !arm && (state == ARMED || state == POST);

  assign trig_fire = (state == ARMED) && (trig_ch != 8'd0) && (trig_ch <= 8'(NUM_CH))
                     && (pick(bus.probe_bus, trig_ch) == trig_val);

  // Entry 0 is the oldest valid sample; once full this is the slot at wr_ptr.
  assign rd_idx = wr_ptr - count[PTR_W-1:0] + e[PTR_W-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.probe_bus),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // A read of the slot being overwritten this cycle returns the new sample.
  assign entry = (wr_en && rd_idx == wr_ptr) ? bus.probe_bus : ram_rdata;

  always_comb begin
    rd_data = '0;
    if (page == LIVE) begin
      rd_data = pick(bus.probe_bus, ch);
    end else if (page == STATUS) begin
      case (ch)
        ST_STATE:    rd_data = {30'b0, state};
        ST_COUNT:    rd_data = 32'(count);
        ST_PRE_TRIG: rd_data = 32'(pre_trig);
        ST_TRIG_HIT: rd_data = {31'b0, trig_hit};
        default:     rd_data = '0;
      endcase
    end else if (page <= 8'(DEPTH) && {1'b0, e} < 9'(count)) begin
      rd_data = pick(entry, ch);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      count          <= '0;
      post_cnt       <= '0;
      pre_trig       <= '0;
      trig_hit       <= 1'b0;
      bus.check_data <= '0;
    end else begin
      bus.check_data <= rd_data;
      if (arm) begin
        state    <= ARMED;
        wr_ptr   <= '0;
        count    <= '0;
        post_cnt <= '0;
        trig_hit <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL) count <= count + 1'b1;
        if (trig_fire) begin
          trig_hit <= 1'b1;
          pre_trig <= (count == FULL) ? PTR_W'(DEPTH - 1) : count[PTR_W-1:0];
          state    <= (POST_TRIG == 0) ? DONE : POST;
        end else if (state == POST) begin
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == POST_LAST) state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_probe.sv
// tb/tb_cpu_trace_probe.sv - directed self-checking bench for cpu_trace_probe
module tb_cpu_trace_probe;

  logic        clk;
  logic        rstn;
  logic        arm;
  logic [7:0]  trig_ch;
  logic [31:0] trig_val;
  logic        trig_hit;
  logic        s_arm;
  logic [7:0]  s_trig_ch;
  logic [31:0] s_trig_val;
  logic        s_trig_hit;
  int          checks;
  int          errors;

  cpu_trace_probe_if #(.NUM_CH(20), .DATA_W(32)) bus_if ();
  cpu_trace_probe_if #(.NUM_CH(4),  .DATA_W(8))  sbus_if ();

  cpu_trace_probe #(.NUM_CH(20), .DATA_W(32), .DEPTH(16), .POST_TRIG(4)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus_if),
    .arm      (arm),
    .trig_ch  (trig_ch),
    .trig_val (trig_val),
    .trig_hit (trig_hit)
  );

  cpu_trace_probe #(.NUM_CH(4), .DATA_W(8), .DEPTH(16), .POST_TRIG(4)) u_small (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (sbus_if),
    .arm      (s_arm),
    .trig_ch  (s_trig_ch),
    .trig_val (s_trig_val),
    .trig_hit (s_trig_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus_if.check_addr = a;
    tick();
    chk(tag, bus_if.check_data, exp);
  endtask

  task automatic srd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    sbus_if.check_addr = a;
    tick();
    chk(tag, sbus_if.check_data, exp);
  endtask

  task automatic smp(input logic [31:0] v1);
    bus_if.probe_bus[31:0] = v1;
    bus_if.probe_valid = 1'b1;
    tick();
    bus_if.probe_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    arm = 1'b0;
    trig_ch = 8'd1;
    trig_val = 32'hFFFF_FFFF;
    bus_if.probe_bus = '0;
    bus_if.probe_valid = 1'b0;
    bus_if.check_addr = '0;
    s_arm = 1'b0;
    s_trig_ch = 8'd4;
    s_trig_val = 32'h1AB;
    sbus_if.probe_bus = '0;
    sbus_if.probe_valid = 1'b0;
    sbus_if.check_addr = '0;
    tick();
    tick();
    chk("rst_check_data", bus_if.check_data, 32'h0);
    rstn = 1'b1;

    // Status after reset.
    rd(32'h0000_FF00, "rst_state", 32'h0);
    rd(32'h0000_FF01, "rst_count", 32'h0);
    rd(32'h0000_FF02, "rst_pre_trig", 32'h0);
    rd(32'h0000_FF03, "rst_trig_hit", 32'h0);

    // Live reads.
    bus_if.probe_bus[63:32] = 32'h1C;
    rd(32'h0000_0002, "live_ch2", 32'h1C);
    rd(32'h0000_0000, "live_ch0", 32'h0);
    rd(32'h0000_0015, "live_ch21", 32'h0);
    rd(32'hABCD_0002, "live_hi_ignored", 32'h1C);

    // Short capture without trigger.
    do_arm();
    smp(32'h10);
    smp(32'h14);
    smp(32'h18);
    rd(32'h0000_FF00, "short_state", 32'h1);
    rd(32'h0000_FF01, "short_count", 32'h3);
    rd(32'h0000_0101, "short_e0", 32'h10);
    rd(32'h0000_0201, "short_e1", 32'h14);
    rd(32'h0000_0301, "short_e2", 32'h18);
    rd(32'h0000_0401, "short_e3", 32'h0);
    rd(32'h0000_0102, "short_e0_ch2", 32'h1C);
    rd(32'h0000_0100, "short_e0_ch0", 32'h0);

    // Full triggered capture: trigger at i=16, four post samples, then frozen.
    trig_val = 32'h40;
    do_arm();
    for (int i = 0; i < 30; i++) smp(32'(4 * i));
    rd(32'h0000_FF00, "trig_state", 32'h3);
    rd(32'h0000_FF01, "trig_count", 32'd16);
    rd(32'h0000_FF02, "trig_pre_trig", 32'd15);
    rd(32'h0000_FF03, "trig_hit_stat", 32'h1);
    chk("trig_hit_port", {31'b0, trig_hit}, 32'h1);
    rd(32'h0000_0101, "trig_oldest", 32'h14);
    rd(32'h0000_1001, "trig_newest", 32'h50);
    rd(32'h0000_1101, "trig_page17", 32'h0);
    rd(32'h0000_FE00, "bad_page", 32'h0);

    // Further samples in DONE leave the trace alone.
    smp(32'h777);
    rd(32'h0000_1001, "done_frozen", 32'h50);

    // arm together with probe_valid: no sample stored.
    bus_if.probe_bus[31:0] = 32'h99;
    bus_if.probe_valid = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    bus_if.probe_valid = 1'b0;
    rd(32'h0000_FF01, "armpv_count", 32'h0);
    rd(32'h0000_FF00, "armpv_state", 32'h1);
    rd(32'h0000_0101, "armpv_e0", 32'h0);
    chk("armpv_trig_hit", {31'b0, trig_hit}, 32'h0);

    // Reset while in POST.
    do_arm();
    for (int i = 0; i < 18; i++) smp(32'(4 * i));
    rd(32'h0000_FF00, "post_state", 32'h2);
    chk("post_trig_hit", {31'b0, trig_hit}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("async_rst_cdata", bus_if.check_data, 32'h0);
    chk("async_rst_trig_hit", {31'b0, trig_hit}, 32'h0);
    tick();
    rstn = 1'b1;
    rd(32'h0000_FF00, "after_rst_state", 32'h0);
    rd(32'h0000_FF01, "after_rst_count", 32'h0);
    rd(32'h0000_0101, "after_rst_e0", 32'h0);

    // Clean capture after reset, trigger on second sample.
    trig_val = 32'h22;
    do_arm();
    smp(32'h21);
    smp(32'h22);
    smp(32'h23);
    rd(32'h0000_FF00, "clean_state", 32'h2);
    rd(32'h0000_FF01, "clean_count", 32'h3);
    rd(32'h0000_FF02, "clean_pre_trig", 32'h1);
    rd(32'h0000_0201, "clean_e1", 32'h22);

    // Invalid trigger channel never fires.
    trig_ch = 8'd0;
    trig_val = 32'h0;
    do_arm();
    bus_if.probe_bus = '0;
    smp(32'h0);
    rd(32'h0000_FF03, "trig_ch0_no_hit", 32'h0);

    // Narrow instance: 4 channels of 8 bits.
    sbus_if.probe_bus = 32'hAB00_0000;
    srd(32'h0000_0004, "small_live_ch4", 32'h0000_00AB);
    srd(32'h0000_0005, "small_live_ch5", 32'h0);
    s_arm = 1'b1;
    tick();
    s_arm = 1'b0;
    sbus_if.probe_valid = 1'b1;
    tick();
    sbus_if.probe_valid = 1'b0;
    srd(32'h0000_FF00, "small_no_trig_state", 32'h1);
    chk("small_no_trig_hit", {31'b0, s_trig_hit}, 32'h0);
    s_trig_val = 32'hAB;
    sbus_if.probe_valid = 1'b1;
    tick();
    sbus_if.probe_valid = 1'b0;
    srd(32'h0000_FF00, "small_trig_state", 32'h2);
    srd(32'h0000_0204, "small_e1_ch4", 32'hAB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
